// File: rtl/exp_result_bcd.sv
// Converts the e^x unit's binary fraction into NDIG BCD digits (multiply-by-10 per cycle)
// and presents it via valid/ready. Define EXP_BCD_ROUND_EN to round the last digit.
module exp_result_bcd #(
    parameter int NDIG = 4,
    parameter int FW   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_done,
    input  logic [1:0]           in_int,
    input  logic [FW-1:0]        in_frac,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           bcd_int,
    output logic [4*NDIG-1:0]    bcd_frac,
    output logic                 overrun
);

    localparam int CW = (NDIG < 2) ? 1 : $clog2(NDIG + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CONV  = 2'd1,
        S_ROUND = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [FW-1:0]       r_frac_q, r_frac_d;
    logic [3:0]          bcd_int_q, bcd_int_d;
    logic [4*NDIG-1:0]   bcd_frac_q, bcd_frac_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                overrun_q, overrun_d;

    logic [FW+3:0]       prod;
    logic [3:0]          digit;
    logic                capture;
    logic                handshake;
`ifdef EXP_BCD_ROUND_EN
    logic [4*NDIG-1:0]   rnd_frac;
    logic                rnd_carry;
`endif

    // Multiply by ten as shift-and-add; the top nibble is the next decimal digit.
    always_comb begin
        prod  = ({4'b0, r_frac_q} << 3) + ({4'b0, r_frac_q} << 1);
        digit = prod[FW+3:FW];
    end

`ifdef EXP_BCD_ROUND_EN
    // Decimal increment of the fraction, rippling from the LSD upward.
    always_comb begin
        rnd_frac  = bcd_frac_q;
        rnd_carry = r_frac_q[FW-1];
        for (int k = 0; k < NDIG; k++) begin
            if (rnd_carry) begin
                if (rnd_frac[4*k +: 4] == 4'd9) begin
                    rnd_frac[4*k +: 4] = 4'd0;
                end else begin
                    rnd_frac[4*k +: 4] = rnd_frac[4*k +: 4] + 4'd1;
                    rnd_carry          = 1'b0;
                end
            end
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        r_frac_d   = r_frac_q;
        bcd_int_d  = bcd_int_q;
        bcd_frac_d = bcd_frac_q;
        cnt_d      = cnt_q;
        overrun_d  = overrun_q;

        handshake = (state_q == S_HOLD) && out_ready;
        capture   = in_done && ((state_q == S_IDLE) || handshake);

        if (in_done && !capture) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: ;
            S_CONV: begin
                r_frac_d        = prod[FW-1:0];
                bcd_frac_d      = bcd_frac_q << 4;
                bcd_frac_d[3:0] = digit;
                cnt_d           = cnt_q + 1'b1;
                if (cnt_q == CW'(NDIG - 1)) begin
`ifdef EXP_BCD_ROUND_EN
                    state_d = S_ROUND;
`else
                    state_d = S_HOLD;
`endif
                end
            end
`ifdef EXP_BCD_ROUND_EN
            S_ROUND: begin
                bcd_frac_d = rnd_frac;
                bcd_int_d  = bcd_int_q + {3'b000, rnd_carry};
                state_d    = S_HOLD;
            end
`endif
            S_HOLD: begin
                if (handshake) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A capture overrides whatever the current state decided (IDLE or HOLD exit).
        if (capture) begin
            r_frac_d   = in_frac;
            bcd_int_d  = {2'b00, in_int};
            bcd_frac_d = '0;
            cnt_d      = '0;
            state_d    = S_CONV;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            r_frac_q   <= '0;
            bcd_int_q  <= '0;
            bcd_frac_q <= '0;
            cnt_q      <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_frac_q   <= r_frac_d;
            bcd_int_q  <= bcd_int_d;
            bcd_frac_q <= bcd_frac_d;
            cnt_q      <= cnt_d;
            overrun_q  <= overrun_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_HOLD);
    assign bcd_int   = bcd_int_q;
    assign bcd_frac  = bcd_frac_q;
    assign overrun   = overrun_q;

endmodule
